mw_add_sequencer: RTL

//  Multi-word adder sequencer. Adds two NWORDS*32-bit operands by time-sharing one
//  rca_32_bit instance, one 32-bit word per cycle, LSW first, with the carry held in a register.

---
 rtl/mw_add_sequencer_pkg.sv | 13 +
 rtl/mw_add_sequencer_rca.sv | 24 ++
 rtl/mw_add_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/mw_add_sequencer_pkg.sv
// Shared word width and FSM state encodings for the multi-word add sequencer.
package mw_add_sequencer_pkg;

  localparam int WORD_W = 32;

  // 2'd3 is unused; the FSM treats it as illegal and returns to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mw_add_sequencer_rca.sv
// 32-bit ripple-carry adder built from a chain of full-adder cells.
module rca_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic        cout,
  output logic [31:0] sum
);

  logic [32:0] carry;

  assign carry[0] = cin;

  // One full-adder cell per bit; the carry ripples from bit 0 upward.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[32];

endmodule

// File: rtl/mw_add_sequencer.sv
// Multi-word adder: time-shares one 32-bit ripple adder across NWORDS words,
// least significant word first, carrying between words in a register.
module mw_add_sequencer
  import mw_add_sequencer_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NWORDS*WORD_W-1:0] a,
  input  logic [NWORDS*WORD_W-1:0] b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [NWORDS*WORD_W-1:0] sum,
  output logic                     cout
);

  localparam int OP_W  = NWORDS * WORD_W;
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                carry_q;
  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;

  logic [WORD_W-1:0]   add_a;
  logic [WORD_W-1:0]   add_b;
  logic [WORD_W-1:0]   add_sum;
  logic                add_cout;

  // Word selection from the captured operands; only a_q/b_q feed the adder.
  assign add_a = a_q[idx*WORD_W +: WORD_W];
  assign add_b = b_q[idx*WORD_W +: WORD_W];

  rca_32_bit u_rca (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .cout (add_cout),
    .sum  (add_sum)
  );

  // Status flags decode straight from the state register, so no input reaches them.
  assign busy = (state == ST_ADD);
  assign done = (state == ST_DONE);

  // Sequencer FSM, operand capture, carry chaining and result accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            state   <= ST_ADD;
          end
        end
        ST_ADD: begin
          sum[idx*WORD_W +: WORD_W] <= add_sum;
          carry_q                   <= add_cout;
          if (idx == LAST_IDX) begin
            cout  <= add_cout;
            idx   <= '0;
            state <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          // A start here is accepted immediately, giving back-to-back operation.
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            state   <= ST_ADD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          idx   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
